// File: rtl/aes_vector_sequencer.sv
// Steps NUM_VEC stored AES-128 vectors through the core under test and scores each result.
// Per vector: FETCH, LOAD, START, then up to TIMEOUT WAIT cycles, then CHECK; go is ignored while busy.
module aes_vector_sequencer #(
    parameter int NUM_VEC = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    output logic [ADDR_W-1:0] vec_addr,
    input  logic [127:0]      vec_key,
    input  logic [127:0]      vec_pt,
    input  logic [127:0]      vec_ct,
    output logic [127:0]      aes_key,
    output logic [127:0]      aes_din,
    output logic              aes_start,
    input  logic              aes_done,
    input  logic [127:0]      aes_dout,
    output logic              busy,
    output logic              finished,
    output logic [ADDR_W:0]   pass_cnt,
    output logic [ADDR_W:0]   fail_cnt,
    output logic              timeout_seen,
    output logic              first_fail_valid,
    output logic [ADDR_W-1:0] first_fail_idx
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_CHECK = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VEC - 1);
    localparam logic [TO_W-1:0]   WAIT_MAX = TO_W'(TIMEOUT - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [127:0]      key_q, key_d;
    logic [127:0]      din_q, din_d;
    logic [127:0]      exp_q, exp_d;
    logic [127:0]      res_q, res_d;
    logic [TO_W-1:0]   wcnt_q, wcnt_d;
    logic              tout_q, tout_d;
    logic [ADDR_W:0]   pass_q, pass_d;
    logic [ADDR_W:0]   fail_q, fail_d;
    logic              tseen_q, tseen_d;
    logic              ffv_q, ffv_d;
    logic [ADDR_W-1:0] ffi_q, ffi_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        key_d   = key_q;
        din_d   = din_q;
        exp_d   = exp_q;
        res_d   = res_q;
        wcnt_d  = wcnt_q;
        tout_d  = tout_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        tseen_d = tseen_q;
        ffv_d   = ffv_q;
        ffi_d   = ffi_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (go) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                    pass_d  = '0;
                    fail_d  = '0;
                    tseen_d = 1'b0;
                    ffv_d   = 1'b0;
                    ffi_d   = '0;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                key_d   = vec_key;
                din_d   = vec_pt;
                exp_d   = vec_ct;
                state_d = S_START;
            end
            S_START: begin
                wcnt_d  = '0;
                tout_d  = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done on the last allowed cycle still wins over the timeout
                if (aes_done) begin
                    res_d   = aes_dout;
                    state_d = S_CHECK;
                end else if (wcnt_q == WAIT_MAX) begin
                    tout_d  = 1'b1;
                    state_d = S_CHECK;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (!tout_q && (res_q == exp_q)) begin
                    pass_d = pass_q + 1'b1;
                end else begin
                    fail_d  = fail_q + 1'b1;
                    tseen_d = tseen_q | tout_q;
                    if (!ffv_q) begin
                        ffv_d = 1'b1;
                        ffi_d = idx_q;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            key_q   <= '0;
            din_q   <= '0;
            exp_q   <= '0;
            res_q   <= '0;
            wcnt_q  <= '0;
            tout_q  <= 1'b0;
            pass_q  <= '0;
            fail_q  <= '0;
            tseen_q <= 1'b0;
            ffv_q   <= 1'b0;
            ffi_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            key_q   <= key_d;
            din_q   <= din_d;
            exp_q   <= exp_d;
            res_q   <= res_d;
            wcnt_q  <= wcnt_d;
            tout_q  <= tout_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            tseen_q <= tseen_d;
            ffv_q   <= ffv_d;
            ffi_q   <= ffi_d;
        end
    end

    // Status and the start pulse decode straight from the state register
    assign vec_addr         = idx_q;
    assign aes_key          = key_q;
    assign aes_din          = din_q;
    assign aes_start        = (state_q == S_START);
    assign busy             = (state_q != S_IDLE) && (state_q != S_DONE);
    assign finished         = (state_q == S_DONE);
    assign pass_cnt         = pass_q;
    assign fail_cnt         = fail_q;
    assign timeout_seen     = tseen_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_idx   = ffi_q;

endmodule

// File: tb/tb_aes_vector_sequencer.sv
// Directed-plus-random bench for aes_vector_sequencer with a vector store, a core model and a run-level reference model.
module tb_aes_vector_sequencer;

    localparam int NV    = 4;
    localparam int TO    = 64;
    localparam int NEVER = 1000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         go = 1'b0;
    logic [3:0]   vec_addr;
    logic [127:0] vec_key = '0;
    logic [127:0] vec_pt = '0;
    logic [127:0] vec_ct = '0;
    logic [127:0] aes_key, aes_din, aes_dout;
    logic         aes_start, aes_done;
    logic         busy, finished, timeout_seen, first_fail_valid;
    logic [4:0]   pass_cnt, fail_cnt;
    logic [3:0]   first_fail_idx;

    logic [127:0] mem_key [0:NV-1];
    logic [127:0] mem_pt  [0:NV-1];
    logic [127:0] mem_ct  [0:NV-1];
    int           dly_tab [0:NV-1];
    bit           flip_tab[0:NV-1];

    logic force_done = 1'b0;
    logic core_done;
    logic armed = 1'b0;
    int   wc = 0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    aes_vector_sequencer #(.NUM_VEC(NV), .ADDR_W(4), .TIMEOUT(TO), .TO_W(7)) dut (
        .clk(clk), .rst(rst), .go(go), .vec_addr(vec_addr),
        .vec_key(vec_key), .vec_pt(vec_pt), .vec_ct(vec_ct),
        .aes_key(aes_key), .aes_din(aes_din), .aes_start(aes_start),
        .aes_done(aes_done), .aes_dout(aes_dout),
        .busy(busy), .finished(finished), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .timeout_seen(timeout_seen), .first_fail_valid(first_fail_valid),
        .first_fail_idx(first_fail_idx)
    );

    // Vector store with one cycle of read latency
    always @(posedge clk) begin
        vec_key <= mem_key[vec_addr[1:0]];
        vec_pt  <= mem_pt[vec_addr[1:0]];
        vec_ct  <= mem_ct[vec_addr[1:0]];
    end

    // Core model: done arrives dly_tab[i] cycles into WAIT, optionally with bit 0 corrupted
    always @(posedge clk) begin
        if (rst) begin
            armed <= 1'b0;
            wc    <= 0;
        end else if (aes_start) begin
            armed <= 1'b1;
            wc    <= 0;
        end else if (armed) begin
            wc <= wc + 1;
            if (core_done || wc > 2 * NEVER) armed <= 1'b0;
        end
    end

    assign core_done = armed && (wc == dly_tab[vec_addr[1:0]]);
    assign aes_done  = core_done | force_done;
    assign aes_dout  = mem_ct[vec_addr[1:0]] ^ {127'd0, flip_tab[vec_addr[1:0]]};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chkn({pfx, "_addr"}, int'(vec_addr), 0);
        chk({pfx, "_key"}, aes_key, 128'd0);
        chk({pfx, "_din"}, aes_din, 128'd0);
        chkn({pfx, "_start"}, int'(aes_start), 0);
        chkn({pfx, "_busy"}, int'(busy), 0);
        chkn({pfx, "_fin"}, int'(finished), 0);
        chkn({pfx, "_pass"}, int'(pass_cnt), 0);
        chkn({pfx, "_fail"}, int'(fail_cnt), 0);
        chkn({pfx, "_tseen"}, int'(timeout_seen), 0);
        chkn({pfx, "_ffv"}, int'(first_fail_valid), 0);
        chkn({pfx, "_ffi"}, int'(first_fail_idx), 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NV; i++) begin
            mem_key[i]  = {$urandom, $urandom, $urandom, $urandom};
            mem_pt[i]   = {$urandom, $urandom, $urandom, $urandom};
            mem_ct[i]   = {$urandom, $urandom, $urandom, $urandom};
            dly_tab[i]  = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, 20));
            flip_tab[i] = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic set_dly(input int d);
        for (int i = 0; i < NV; i++) begin
            dly_tab[i]  = d;
            flip_tab[i] = 1'b0;
        end
    endtask

    // One complete run from go to finished, scored against the reference model
    task automatic run(input string tag, input bit inj_start_done, input bit go_mid);
        int  exp_cyc, exp_pass, exp_fail, exp_ffi, w, edges, nstarts;
        bit  exp_ffv, exp_tseen, to;
        exp_cyc = 0; exp_pass = 0; exp_fail = 0; exp_ffi = 0;
        exp_ffv = 1'b0; exp_tseen = 1'b0;
        for (int i = 0; i < NV; i++) begin
            to = (dly_tab[i] >= TO);
            w  = to ? TO : dly_tab[i] + 1;
            exp_cyc += 4 + w;
            if (!to && !flip_tab[i]) begin
                exp_pass++;
            end else begin
                exp_fail++;
                exp_tseen |= to;
                if (!exp_ffv) begin
                    exp_ffv = 1'b1;
                    exp_ffi = i;
                end
            end
        end

        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        chkn({tag, "_go_busy"}, int'(busy), 1);
        chkn({tag, "_go_fin"}, int'(finished), 0);
        chkn({tag, "_go_addr"}, int'(vec_addr), 0);
        chkn({tag, "_go_pass"}, int'(pass_cnt), 0);
        chkn({tag, "_go_fail"}, int'(fail_cnt), 0);
        chkn({tag, "_go_tseen"}, int'(timeout_seen), 0);
        chkn({tag, "_go_ffv"}, int'(first_fail_valid), 0);

        edges = 0;
        nstarts = 0;
        while (!finished && edges < 2000) begin
            @(negedge clk);
            edges++;
            force_done = 1'b0;
            go = 1'b0;
            if (aes_start) begin
                if (nstarts < NV) begin
                    chk({tag, "_key"}, aes_key, mem_key[nstarts]);
                    chk({tag, "_din"}, aes_din, mem_pt[nstarts]);
                end
                nstarts++;
                if (inj_start_done) force_done = 1'b1;
            end
            if (go_mid && edges == 7) go = 1'b1;
        end
        force_done = 1'b0;
        go = 1'b0;

        chkn({tag, "_cycles"}, edges, exp_cyc);
        chkn({tag, "_starts"}, nstarts, NV);
        chkn({tag, "_busy"}, int'(busy), 0);
        chkn({tag, "_pass"}, int'(pass_cnt), exp_pass);
        chkn({tag, "_fail"}, int'(fail_cnt), exp_fail);
        chkn({tag, "_tseen"}, int'(timeout_seen), int'(exp_tseen));
        chkn({tag, "_ffv"}, int'(first_fail_valid), int'(exp_ffv));
        chkn({tag, "_ffi"}, int'(first_fail_idx), exp_ffi);
    endtask

    initial begin
        int n;
        fill_random();
        set_dly(10);

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Stray done while idle must not move anything
        @(negedge clk); force_done = 1'b1;
        @(negedge clk); force_done = 1'b0;
        @(negedge clk);
        chk_all_zero("idle_done");

        run("all_pass", 1'b0, 1'b0);

        flip_tab[2] = 1'b1;
        run("flip2", 1'b0, 1'b0);

        set_dly(10);
        dly_tab[1] = NEVER;
        run("timeout1", 1'b0, 1'b0);

        // Done on the last allowed WAIT cycle passes; one cycle later is a timeout
        set_dly(3);
        dly_tab[0] = TO - 1;
        dly_tab[3] = TO;
        run("edge_to", 1'b0, 1'b1);

        fill_random();
        run("start_done", 1'b1, 1'b0);

        // Reset in the WAIT of vector 3 aborts the run on the spot
        fill_random();
        set_dly(20);
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        n = 0;
        for (int c = 0; c < 2000 && n < 4; c++) begin
            @(negedge clk);
            if (aes_start) n++;
        end
        chkn("abort_reached_v3", n, 4);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk_all_zero("abort");
        @(negedge clk);
        chkn("abort_no_start", int'(aes_start), 0);
        chkn("abort_idle", int'(busy), 0);

        for (int r = 0; r < 6; r++) begin
            fill_random();
            run($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_vector_sequencer.md
Name: aes_vector_sequencer

Overview:
Verification-platform controller that runs a stored list of AES-128 test vectors through the AES core under test. For each vector it fetches key, plaintext and expected ciphertext from a vector store, loads the core, and issues a start pulse. It then waits for done under a timeout and compares the result against the expected ciphertext. Running pass/fail counts and first-failure information go to the platform scoreboard and reporting logic.

Parameters:
NUM_VEC, 16, number of vectors per run (≥1, ≤2^ADDR_W)
ADDR_W, 4, vector-store address width
TIMEOUT, 64, max WAIT cycles per vector before declaring timeout (≥2)
TO_W, 7, wait-counter width; must hold TIMEOUT-1

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
go  in  1  start-of-run pulse; honoured only in IDLE or DONE
vec_addr  out  ADDR_W  vector-store address
vec_key  in  128  key at vec_addr, valid 1 cycle after vec_addr changes
vec_pt  in  128  plaintext, same timing as vec_key
vec_ct  in  128  expected ciphertext, same timing as vec_key
aes_key  out  128  key to core, registered
aes_din  out  128  plaintext to core, registered
aes_start  out  1  single-cycle start pulse to core
aes_done  in  1  core completion strobe
aes_dout  in  128  core result, valid when aes_done=1
busy  out  1  high from go acceptance until DONE
finished  out  1  high in DONE until next go or rst
pass_cnt  out  ADDR_W+1  vectors matched this run
fail_cnt  out  ADDR_W+1  vectors mismatched or timed out this run
timeout_seen  out  1  sticky: at least one timeout this run
first_fail_valid  out  1  sticky: a failure has been recorded
first_fail_idx  out  ADDR_W  index of first failing vector

Behaviour:
- Reset: the following are all 0 and the state is IDLE:
  - vec_addr, aes_key, aes_din, aes_start, busy, finished
  - pass_cnt, fail_cnt, timeout_seen, first_fail_valid, first_fail_idx
  - internal index, wait counter, expected and result registers
- rst mid-run aborts immediately; aes_start is never asserted in the cycle after rst.
- States: IDLE, FETCH, LOAD, START, WAIT, CHECK, DONE.
- IDLE/DONE + go:
  - Clear counters, sticky flags and first_fail_idx; idx=0; vec_addr=0; busy=1; finished=0; next state FETCH.
  - go in any other state is ignored.
- FETCH: one cycle for vector-store latency; vec_addr=idx.
- LOAD: capture aes_key←vec_key, aes_din←vec_pt, exp←vec_ct.
- START: aes_start=1 for exactly this cycle; clear wait counter.
- WAIT: aes_done is sampled each cycle, first WAIT cycle = count 0.
  - aes_done=1: capture aes_dout, go to CHECK.
  - Else, count==TIMEOUT-1: set timeout flag for this vector, go to CHECK.
  - Else count++.
  - WAIT therefore lasts at most TIMEOUT cycles.
- aes_done outside WAIT, including in the START cycle, is ignored.
- CHECK (one cycle):
  - Pass: no timeout and result==exp; pass_cnt++.
  - Otherwise fail_cnt++; timeout_seen|=timeout.
  - On the first failure only: first_fail_valid=1, first_fail_idx=idx.
  - If idx==NUM_VEC-1, go to DONE; else idx++, vec_addr=idx+1, go to FETCH.
- DONE: busy=0, finished=1; counters hold.
- Per-vector cycles: 4 + W, where W = number of WAIT cycles (W = k+1 when done arrives at count k).
- Invariant: pass_cnt+fail_cnt = vectors checked; at DONE it equals NUM_VEC.
- Counters never wrap: width ADDR_W+1 holds NUM_VEC.

Test Plan:
- NUM_VEC=4, core model asserts aes_done 10 cycles after aes_start with correct ciphertext, go pulse -> aes_start 4 times; each vector 15 cycles (4 + 11 WAIT cycles), so finished rises 60 cycles after go; pass_cnt=4, fail_cnt=0, first_fail_valid=0.
- Same run, core returns ciphertext with bit 0 flipped on vector 2 -> pass_cnt=3, fail_cnt=1, first_fail_valid=1, first_fail_idx=2, timeout_seen=0.
- Core never asserts done for vector 1 -> exactly 64 WAIT cycles, then CHECK; fail_cnt=1, timeout_seen=1, first_fail_idx=1; vector 2 fetched next and the run completes.
- rst asserted in WAIT of vector 3 -> next cycle all outputs 0 and IDLE; a later go restarts at vec_addr=0 with counters from 0.
- go re-pulsed while busy -> ignored, count unaffected; go in DONE -> counters and flags cleared, busy=1, new run starts.
- aes_done pulsed in IDLE and in the START cycle -> no count change, no state change beyond the normal sequence.
